pll_acq_sequencer: RTL

- Acquisition/lock sequencer for the software-style DPLL clocked from clk_50: NCO accumulator, phase comparator, slew logic and lockout timer.
- Brings the loop up in four steps:
  - Open-loop frequency sweep until one VCO edge lands per feedback period.
  - Hands control to the closed-loop slew path.
  - Qualifies lock from phase-error activity.
  - Holds the last frequency word (holdover) when feedback disappears.
- Drives the NCO frequency-override mux and loop-enable gate, and provides locked/state status for LEDs and the display.

---
 rtl/pll_acq_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pll_acq_sequencer.sv
// Acquisition/lock sequencer for the DPLL: open-loop NCO sweep, hand-off to the
// closed loop, lock qualification from phase-error activity, and holdover.
module pll_acq_sequencer #(
   parameter logic [9:0]  FREQ_DEFAULT_RAW = 10'd163,
   parameter logic [9:0]  FREQ_MIN_RAW     = 10'd131,
   parameter logic [9:0]  FREQ_MAX_RAW     = 10'd262,
   parameter logic [3:0]  SWEEP_STEP       = 4'd2,
   parameter logic [3:0]  MATCH_N          = 4'd8,
   parameter logic [15:0] LOCK_ERR_CYC     = 16'd20,
   parameter logic [7:0]  LOCK_N           = 8'd64,
   parameter logic [15:0] UNLOCK_ERR_CYC   = 16'd100,
   parameter logic [15:0] SETTLE_CYC       = 16'd5000,
   parameter logic [23:0] HOLD_TIMEOUT     = 24'd5000000
) (
   input  logic       clk_50,
   input  logic       rst,
   input  logic       restart,
   input  logic       fb_edge,
   input  logic       vco_edge,
   input  logic       lockout,
   input  logic       slew_active,
   input  logic [9:0] freq_in,
   output logic       freq_ovr_en,
   output logic [9:0] freq_ovr,
   output logic       loop_en,
   output logic       locked,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SWEEP    = 3'd1,
      TRACK    = 3'd2,
      LOCKED   = 3'd3,
      HOLDOVER = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  vedge_cnt, vedge_d, vedge_tot;
   logic [15:0] err_cnt, err_d, err_tot;
   logic [15:0] settle_cnt, settle_d;
   logic [3:0]  match_cnt, match_d;
   logic [7:0]  quiet_cnt, quiet_d;
   logic [23:0] hold_cnt, hold_d;
   logic        primed, primed_d, eval, enter;
   logic [9:0]  freq_d, freq_up, freq_dn;
   logic [10:0] sweep_up;

   // Running totals include this cycle's pulses so an fb_edge cycle closes the period in full.
   assign vedge_tot = (vco_edge && vedge_cnt != 2'd3) ? vedge_cnt + 2'd1 : vedge_cnt;
   assign err_tot   = (slew_active && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
   assign eval      = fb_edge && primed;

   // Sweep arithmetic is done one bit wider so neither direction can wrap.
   assign sweep_up = {1'b0, freq_ovr} + {7'd0, SWEEP_STEP};
   assign freq_up  = (sweep_up > {1'b0, FREQ_MAX_RAW}) ? FREQ_MAX_RAW : sweep_up[9:0];
   assign freq_dn  = ({1'b0, freq_ovr} < ({1'b0, FREQ_MIN_RAW} + {7'd0, SWEEP_STEP}))
                     ? FREQ_MIN_RAW : freq_ovr - {6'd0, SWEEP_STEP};

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can infer a latch.
      state_d  = state_q;
      freq_d   = freq_ovr;
      settle_d = settle_cnt;
      match_d  = match_cnt;
      quiet_d  = quiet_cnt;
      hold_d   = hold_cnt;
      vedge_d  = fb_edge ? 2'd0 : vedge_tot;
      err_d    = fb_edge ? 16'd0 : err_tot;

      case (state_q)
         IDLE: begin
            if (lockout) settle_d = 16'd0;
            else if (settle_cnt == SETTLE_CYC - 16'd1) begin
               state_d = SWEEP;
               freq_d  = FREQ_DEFAULT_RAW;
            end else settle_d = settle_cnt + 16'd1;
         end
         SWEEP: begin
            if (lockout) state_d = IDLE;
            else if (eval) begin
               if (vedge_tot == 2'd0) begin
                  freq_d  = freq_up;
                  match_d = 4'd0;
               end else if (vedge_tot == 2'd1) begin
                  if (match_cnt == MATCH_N - 4'd1) state_d = TRACK;
                  else match_d = match_cnt + 4'd1;
               end else begin
                  freq_d  = freq_dn;
                  match_d = 4'd0;
               end
            end
         end
         TRACK: begin
            if (lockout) begin
               state_d = HOLDOVER;
               freq_d  = freq_in;
            end else if (eval) begin
               if (err_tot <= LOCK_ERR_CYC) begin
                  if (quiet_cnt == LOCK_N - 8'd1) state_d = LOCKED;
                  else quiet_d = quiet_cnt + 8'd1;
               end else quiet_d = 8'd0;
            end
         end
         LOCKED: begin
            if (lockout) begin
               state_d = HOLDOVER;
               freq_d  = freq_in;
            end else if (eval && err_tot > UNLOCK_ERR_CYC) state_d = TRACK;
         end
         HOLDOVER: begin
            if (lockout) begin
               settle_d = 16'd0;
               if (hold_cnt == HOLD_TIMEOUT - 24'd1) state_d = IDLE;
               else hold_d = hold_cnt + 24'd1;
            end else if (settle_cnt == SETTLE_CYC - 16'd1) state_d = TRACK;
            else settle_d = settle_cnt + 16'd1;
         end
         default: state_d = IDLE;
      endcase

      if (restart) state_d = IDLE;
      if (state_d == IDLE) freq_d = FREQ_DEFAULT_RAW;

      // Any state entry restarts all per-state counters and skips the first period.
      enter = restart || (state_d != state_q);
      if (enter) begin
         settle_d = 16'd0;
         match_d  = 4'd0;
         quiet_d  = 8'd0;
         hold_d   = 24'd0;
      end
      primed_d = enter ? 1'b0 : (fb_edge ? 1'b1 : primed);
   end

   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         freq_ovr    <= FREQ_DEFAULT_RAW;
         freq_ovr_en <= 1'b1;
         loop_en     <= 1'b0;
         locked      <= 1'b0;
         vedge_cnt   <= 2'd0;
         err_cnt     <= 16'd0;
         settle_cnt  <= 16'd0;
         match_cnt   <= 4'd0;
         quiet_cnt   <= 8'd0;
         hold_cnt    <= 24'd0;
         primed      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         freq_ovr    <= freq_d;
         freq_ovr_en <= (state_d == IDLE) || (state_d == SWEEP) || (state_d == HOLDOVER);
         loop_en     <= (state_d == TRACK) || (state_d == LOCKED);
         locked      <= (state_d == LOCKED);
         vedge_cnt   <= vedge_d;
         err_cnt     <= err_d;
         settle_cnt  <= settle_d;
         match_cnt   <= match_d;
         quiet_cnt   <= quiet_d;
         hold_cnt    <= hold_d;
         primed      <= primed_d;
      end
   end

   assign state = state_q;

endmodule
